rr_sel_arb4: RTL and testbench

RR_SEL_ARB4 -- requirements
Module: rr_sel_arb4

---
 rtl/rr_arb_pkg.sv | 28 ++
 rtl/rr_pri_enc4.sv | 45 ++++
 rtl/rr_sel_arb4.sv | 136 +++++++++++++
 tb/tb_rr_sel_arb4.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// -----------------------------------------------------------------------------
// rr_arb_pkg
// Shared definitions for the 4-channel round-robin select arbiter.
//   NUM_CH        : number of requesting channels
//   SEL_W         : width of the mux select / pointer
//   state_t       : arbiter FSM encoding (IDLE=0, GRANT=1)
//   DEF_MAX_HOLD  : default maximum grant hold time (timeout build only)
//   onehot()      : select index -> one-hot grant vector
// -----------------------------------------------------------------------------
package rr_arb_pkg;

   localparam int NUM_CH       = 4;
   localparam int SEL_W        = 2;
   localparam int DEF_MAX_HOLD = 8;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   function automatic logic [NUM_CH-1:0] onehot(input logic [SEL_W-1:0] idx);
      logic [NUM_CH-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/rr_pri_enc4.sv
// -----------------------------------------------------------------------------
// rr_pri_enc4
// Combinational rotating-priority encoder. Finds the first set request bit
// searching ptr, ptr+1, ... (mod 4).
// Ports:
//   req [3:0] in  : per-channel requests
//   ptr [1:0] in  : highest-priority channel for this search
//   idx [1:0] out : winning channel (0 when any=0)
//   any       out : at least one request is set
// -----------------------------------------------------------------------------
module rr_pri_enc4
   import rr_arb_pkg::*;
(
   input  logic [NUM_CH-1:0] req,
   input  logic [SEL_W-1:0]  ptr,
   output logic [SEL_W-1:0]  idx,
   output logic              any
);

   // Candidate channel at each search offset, and whether it requests.
   logic [SEL_W-1:0]  w_cand [NUM_CH];
   logic [NUM_CH-1:0] w_hit;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_rot
         // SEL_W-bit addition wraps 3 -> 0 naturally.
         assign w_cand[gi] = ptr + SEL_W'(gi);
         assign w_hit[gi]  = req[w_cand[gi]];
      end
   endgenerate

   // Scan from the lowest-priority offset down so the smallest offset wins.
   always_comb begin
      idx = '0;
      any = 1'b0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (w_hit[k]) begin
            idx = w_cand[k];
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_sel_arb4.sv
// -----------------------------------------------------------------------------
// rr_sel_arb4
// Round-robin arbiter producing a registered select for a downstream 4:1 mux.
// A grant is held until the consumer signals done or the granted channel
// drops its request; at least one IDLE cycle separates consecutive grants.
// After a release the pointer moves to the channel after the one just served.
//
// Optional feature: define RR_SEL_ARB4_TIMEOUT_EN to add an 8-bit hold
// counter that forces release after MAX_HOLD grant cycles and pulses timeout.
// Without it, timeout is tied low and a grant may be held indefinitely.
//
// Parameters:
//   MAX_HOLD     : max grant cycles when the timeout feature is built (2..255)
// Ports:
//   clk          in  : clock, rising edge
//   rst          in  : asynchronous active-high reset
//   req [3:0]    in  : per-channel requests
//   done         in  : consumer finished with the granted channel
//   sel [1:0]    out : registered mux select (holds its value while idle)
//   gnt [3:0]    out : registered one-hot grant, zero when not valid
//   valid        out : mux output selected and owned
//   timeout      out : one-cycle pulse on forced release
// -----------------------------------------------------------------------------
module rr_sel_arb4
   import rr_arb_pkg::*;
#(
   parameter int MAX_HOLD = DEF_MAX_HOLD
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] req,
   input  logic              done,
   output logic [SEL_W-1:0]  sel,
   output logic [NUM_CH-1:0] gnt,
   output logic              valid,
   output logic              timeout
);

   if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
      $error("rr_sel_arb4: MAX_HOLD must be in 2..255");
   end

   state_t            r_state;
   logic [SEL_W-1:0]  r_ptr;
   logic [SEL_W-1:0]  r_sel;
   logic [NUM_CH-1:0] r_gnt;
   logic              r_valid;

   logic [SEL_W-1:0]  w_idx;
   logic              w_any;
   logic              w_force;
   logic              w_release;

   rr_pri_enc4 u_pri_enc (
      .req (req),
      .ptr (r_ptr),
      .idx (w_idx),
      .any (w_any)
   );

`ifdef RR_SEL_ARB4_TIMEOUT_EN
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   logic [7:0] r_hold;
   logic       r_timeout;

   assign w_force = (r_state == ST_GRANT) && (r_hold == HOLD_LAST);

   // Counter is kept at zero while idle so it reads 0 on the first GRANT
   // cycle; the timeout pulse lines up with the cycle valid drops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hold    <= 8'd0;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= w_force;
         if (r_state == ST_IDLE) begin
            r_hold <= 8'd0;
         end else begin
            r_hold <= r_hold + 8'd1;
         end
      end
   end

   assign timeout = r_timeout;
`else
   assign w_force = 1'b0;
   assign timeout = 1'b0;
`endif

   // done, a dropped request and a forced timeout all collapse into one release.
   assign w_release = done || !req[r_sel] || w_force;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_ptr   <= '0;
         r_sel   <= '0;
         r_gnt   <= '0;
         r_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_state <= ST_GRANT;
                  r_sel   <= w_idx;
                  r_gnt   <= onehot(w_idx);
                  r_valid <= 1'b1;
               end else begin
                  r_gnt   <= '0;
                  r_valid <= 1'b0;
               end
            end
            ST_GRANT: begin
               // Other channels' requests are not looked at here.
               if (w_release) begin
                  r_state <= ST_IDLE;
                  r_gnt   <= '0;
                  r_valid <= 1'b0;
                  r_ptr   <= r_sel + SEL_W'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_gnt   <= '0;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign sel   = r_sel;
   assign gnt   = r_gnt;
   assign valid = r_valid;

endmodule

// File: tb/tb_rr_sel_arb4.sv
// -----------------------------------------------------------------------------
// tb_rr_sel_arb4
// Directed stimulus with a scoreboard: the driver pushes the expected outputs
// for the edge following each input vector; a monitor pops and compares one
// entry per clock, one step after the rising edge. Builds with or without
// RR_SEL_ARB4_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_rr_sel_arb4;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic       done;
   logic [1:0] sel;
   logic [3:0] gnt;
   logic       valid;
   logic       timeout;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [1:0] sel;
      logic [3:0] gnt;
      logic       valid;
      logic       to;
      string      name;
   } exp_t;

   exp_t exp_q[$];

   rr_sel_arb4 #(.MAX_HOLD(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .done    (done),
      .sel     (sel),
      .gnt     (gnt),
      .valid   (valid),
      .timeout (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, want, $time);
      end
   endtask

   // Drive one cycle of inputs and record what the next edge must produce.
   task automatic step(input logic [3:0] r, input logic d,
                       input logic [1:0] s, input logic [3:0] g,
                       input logic v, input logic t, input string nm);
      exp_t e;
      @(negedge clk);
      req  = r;
      done = d;
      e.sel = s; e.gnt = g; e.valid = v; e.to = t; e.name = nm;
      exp_q.push_back(e);
   endtask

   // Monitor: one scoreboard entry per clock while out of reset.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            $display("txn %-14s req=%b done=%b -> sel=%0d gnt=%b valid=%b timeout=%b",
                     e.name, req, done, sel, gnt, valid, timeout);
            chk({e.name, ".sel"},     32'(sel),     32'(e.sel));
            chk({e.name, ".gnt"},     32'(gnt),     32'(e.gnt));
            chk({e.name, ".valid"},   32'(valid),   32'(e.valid));
            chk({e.name, ".timeout"}, 32'(timeout), 32'(e.to));
            chk({e.name, ".onehot0"}, 32'($countones(gnt) <= 1), 32'd1);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst  = 1'b0;
      req  = 4'b0000;
      done = 1'b0;
      // Reset asserted between clock edges must act immediately.
      #2 rst = 1'b1;
      #1;
      chk("rst0.sel",     32'(sel),     32'd0);
      chk("rst0.gnt",     32'(gnt),     32'd0);
      chk("rst0.valid",   32'(valid),   32'd0);
      chk("rst0.timeout", 32'(timeout), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Single request, release by done; sel holds while idle.
      step(4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0, "single_grant");
      step(4'b0100, 1'b1, 2'd2, 4'b0000, 1'b0, 1'b0, "single_done");
      step(4'b0000, 1'b0, 2'd2, 4'b0000, 1'b0, 1'b0, "idle_hold");

      // Grant ch2 (ptr=3 now), then reset mid-cycle.
      step(4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0, "pre_rst_grant");
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid.sel",   32'(sel),   32'd0);
      chk("rst_mid.gnt",   32'(gnt),   32'd0);
      chk("rst_mid.valid", 32'(valid), 32'd0);
      @(negedge clk);
      req = 4'b0000;
      @(negedge clk);
      rst = 1'b0;

      // Fairness from ptr=0 with all channels requesting.
      step(4'b1111, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0, "fair_ch0");
      step(4'b1111, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b0, "fair_rel0");
      step(4'b1111, 1'b0, 2'd1, 4'b0010, 1'b1, 1'b0, "fair_ch1");
      step(4'b1111, 1'b1, 2'd1, 4'b0000, 1'b0, 1'b0, "fair_rel1");
      step(4'b1111, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0, "fair_ch2");
      step(4'b1111, 1'b1, 2'd2, 4'b0000, 1'b0, 1'b0, "fair_rel2");
      step(4'b1111, 1'b0, 2'd3, 4'b1000, 1'b1, 1'b0, "fair_ch3");
      step(4'b1111, 1'b1, 2'd3, 4'b0000, 1'b0, 1'b0, "fair_rel3");
      step(4'b1111, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0, "fair_ch0b");
      step(4'b1111, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b0, "fair_rel0b");

      // Wrap: ch3 grant (ptr->0), ch2 grant (ptr->3), then 0011 must pick ch0.
      step(4'b1000, 1'b0, 2'd3, 4'b1000, 1'b1, 1'b0, "wrap_ch3");
      step(4'b1000, 1'b1, 2'd3, 4'b0000, 1'b0, 1'b0, "wrap_rel3");
      step(4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0, "wrap_ch2");
      step(4'b0100, 1'b1, 2'd2, 4'b0000, 1'b0, 1'b0, "wrap_rel2");
      step(4'b0011, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0, "wrap_ch0");
      // Release by dropping the granted request (ptr -> 1).
      step(4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, "wrap_reqdrop");

      // Other requests during a grant are ignored.
      step(4'b0010, 1'b0, 2'd1, 4'b0010, 1'b1, 1'b0, "ign_ch1");
      step(4'b1111, 1'b0, 2'd1, 4'b0010, 1'b1, 1'b0, "ign_others");
      step(4'b1111, 1'b1, 2'd1, 4'b0000, 1'b0, 1'b0, "ign_rel");

      // Long hold on ch0 (ptr=2 -> search 2,3,0).
`ifdef RR_SEL_ARB4_TIMEOUT_EN
      step(4'b0001, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0, "to_grant");
      for (int i = 0; i < 7; i++)
         step(4'b0001, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0, "to_hold");
      step(4'b0001, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1, "to_release");
      step(4'b0001, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0, "to_regrant");
      for (int i = 0; i < 7; i++)
         step(4'b0001, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0, "to_hold2");
      step(4'b0001, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b1, "to_done_same");
      step(4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, "to_idle");
`else
      step(4'b0001, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0, "hold_grant");
      for (int i = 0; i < 110; i++)
         step(4'b0001, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0, "hold_long");
      step(4'b0001, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b0, "hold_done");
`endif

      // Drain the scoreboard within a bounded number of cycles.
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
